// File: rtl/mem_arbiter_rr_if.sv
// Requester/memory bus bundle shared between the requesters and mem_arbiter_rr.
// The master side drives requests and reads grants; the slave side is the arbiter.
interface mem_arbiter_rr_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addrIn;
  logic [NUM_REQ*DATA_WIDTH-1:0] dataIn;
  logic [NUM_REQ-1:0]            readWriteIn;
  logic [NUM_REQ-1:0]            grant;
  logic                          memEnabled;
  logic [ADDR_WIDTH-1:0]         memAddress;
  logic [DATA_WIDTH-1:0]         memDataOut;
  logic                          memReadWrite;
  logic                          revoked;

  modport master (
    output req, addrIn, dataIn, readWriteIn,
    input  grant, memEnabled, memAddress, memDataOut, memReadWrite, revoked
  );

  modport slave (
    input  req, addrIn, dataIn, readWriteIn,
    output grant, memEnabled, memAddress, memDataOut, memReadWrite, revoked
  );

endinterface

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter for the single-port shared memory. Grants one requester at a
// time, muxes its address/data/strobe onto the memory port, and revokes a grant that
// has kept another requester waiting for MAX_HOLD cycles.
module mem_arbiter_rr #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_HOLD   = 16
) (
  input logic             clk,
  input logic             resetN,
  mem_arbiter_rr_if.slave bus
);

  localparam int unsigned OwnW  = $clog2(NUM_REQ);
  // Keep at least one bit so MAX_HOLD = 0 still elaborates; the counter then stays 0.
  localparam int unsigned HoldW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HoldW-1:0] HoldLast = (MAX_HOLD == 0) ? '0 : HoldW'(MAX_HOLD - 1);
  localparam logic [OwnW-1:0]  LastInit = OwnW'(NUM_REQ - 1);

  typedef enum logic {StIdle, StGrant} stateT;

  stateT               stateQ;
  logic [NUM_REQ-1:0]  grantQ;
  logic                revokedQ;
  logic [OwnW-1:0]     lastOwnerQ;
  logic [HoldW-1:0]    holdCntQ;

  logic                pickValid;
  logic [OwnW-1:0]     pick;
  logic                ownerReq;
  logic                othersReq;
  logic [ADDR_WIDTH-1:0] muxAddr;
  logic [DATA_WIDTH-1:0] muxData;
  logic                  muxRw;

  // While granted, lastOwnerQ is the current owner.
  assign ownerReq  = bus.req[lastOwnerQ];
  assign othersReq = |(bus.req & ~grantQ);

  // Next owner: first requester above lastOwnerQ, otherwise wrap to the lowest one.
  always_comb begin
    pickValid = 1'b0;
    pick      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pickValid && bus.req[i] && (OwnW'(i) > lastOwnerQ)) begin
        pickValid = 1'b1;
        pick      = OwnW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pickValid && bus.req[i] && (OwnW'(i) <= lastOwnerQ)) begin
        pickValid = 1'b1;
        pick      = OwnW'(i);
      end
    end
  end

  // Arbitration FSM with registered grant and revoke pulse.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      stateQ     <= StIdle;
      grantQ     <= '0;
      revokedQ   <= 1'b0;
      lastOwnerQ <= LastInit;
      holdCntQ   <= '0;
    end else begin
      revokedQ <= 1'b0;
      unique case (stateQ)
        StIdle: begin
          if (pickValid) begin
            grantQ     <= NUM_REQ'(1) << pick;
            lastOwnerQ <= pick;
            holdCntQ   <= '0;
            stateQ     <= StGrant;
          end
        end
        StGrant: begin
          if (!ownerReq) begin
            grantQ <= '0;
            stateQ <= StIdle;
          end else if ((MAX_HOLD != 0) && othersReq && (holdCntQ == HoldLast)) begin
            grantQ   <= '0;
            revokedQ <= 1'b1;
            stateQ   <= StIdle;
          end else if (othersReq) begin
            // Saturate; with MAX_HOLD = 0 HoldLast is 0 so the counter never moves.
            if (holdCntQ != HoldLast) holdCntQ <= holdCntQ + 1'b1;
          end else begin
            holdCntQ <= '0;
          end
        end
        default: begin
          grantQ <= '0;
          stateQ <= StIdle;
        end
      endcase
    end
  end

  // Memory port mux: OR of the granted slice, all-zero when nobody owns the bus.
  always_comb begin
    muxAddr = '0;
    muxData = '0;
    muxRw   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grantQ[i]) begin
        muxAddr = muxAddr | bus.addrIn[i*ADDR_WIDTH +: ADDR_WIDTH];
        muxData = muxData | bus.dataIn[i*DATA_WIDTH +: DATA_WIDTH];
        muxRw   = muxRw   | bus.readWriteIn[i];
      end
    end
  end

  assign bus.grant        = grantQ;
  assign bus.memEnabled   = |grantQ;
  assign bus.memAddress   = muxAddr;
  assign bus.memDataOut   = muxData;
  assign bus.memReadWrite = muxRw;
  assign bus.revoked      = revokedQ;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: two instances (MAX_HOLD 16 and 0) share one stimulus
// stream; a reference model predicts each cycle's outputs into per-instance queues
// that a negedge monitor drains and compares.
module tb_mem_arbiter_rr;

  localparam int NR   = 4;
  localparam int AW   = 8;
  localparam int DW   = 32;
  localparam int ObsW = NR + 1 + AW + DW + 2;
  typedef logic [ObsW-1:0] obsT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             resetN;
  logic [NR-1:0]    req;
  logic [NR*AW-1:0] addrIn;
  logic [NR*DW-1:0] dataIn;
  logic [NR-1:0]    rwIn;

  mem_arbiter_rr_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) busA ();
  mem_arbiter_rr_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) busB ();

  assign busA.req = req;
  assign busA.addrIn = addrIn;
  assign busA.dataIn = dataIn;
  assign busA.readWriteIn = rwIn;
  assign busB.req = req;
  assign busB.addrIn = addrIn;
  assign busB.dataIn = dataIn;
  assign busB.readWriteIn = rwIn;

  mem_arbiter_rr #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(16)) dutA (
    .clk(clk), .resetN(resetN), .bus(busA)
  );
  mem_arbiter_rr #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(0)) dutB (
    .clk(clk), .resetN(resetN), .bus(busB)
  );

  int checks = 0;
  int errors = 0;
  int cycNo = 0;
  int revSeenB = 0;

  obsT qA[$];
  obsT qB[$];

  // Reference model: owner index (-1 = bus idle), last owner, consecutive contended
  // cycles of the current tenure, revoke pulse.
  int   mOwner[2];
  int   mLast[2];
  int   mCont[2];
  logic mRev[2];
  int   mMax[2];

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic void modelStep(int m);
    logic [NR-1:0] others;
    if (resetN !== 1'b1) begin
      mOwner[m] = -1;
      mLast[m]  = NR - 1;
      mCont[m]  = 0;
      mRev[m]   = 1'b0;
    end else begin
      mRev[m] = 1'b0;
      if (mOwner[m] < 0) begin
        for (int k = 1; k <= NR; k++) begin
          if (req[(mLast[m] + k) % NR]) begin
            mOwner[m] = (mLast[m] + k) % NR;
            mLast[m]  = mOwner[m];
            mCont[m]  = 0;
            break;
          end
        end
      end else if (!req[mOwner[m]]) begin
        mOwner[m] = -1;
      end else begin
        others = req;
        others[mOwner[m]] = 1'b0;
        if (others != 0) begin
          mCont[m]++;
          if (mMax[m] != 0 && mCont[m] == mMax[m]) begin
            mOwner[m] = -1;
            mRev[m]   = 1'b1;
          end
        end else begin
          mCont[m] = 0;
        end
      end
    end
  endfunction

  function automatic obsT expVec(int m);
    logic [NR-1:0] g;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          w;
    g = '0;
    a = '0;
    d = '0;
    w = 1'b0;
    if (mOwner[m] >= 0) begin
      g[mOwner[m]] = 1'b1;
      a = addrIn[mOwner[m]*AW +: AW];
      d = dataIn[mOwner[m]*DW +: DW];
      w = rwIn[mOwner[m]];
    end
    return {g, |g, a, d, w, mRev[m]};
  endfunction

  // Clock edge: advance both models with the inputs that edge sampled.
  task automatic step();
    @(posedge clk);
    #1;
    modelStep(0);
    modelStep(1);
  endtask

  // Inputs for this cycle are final: publish the expected outputs.
  task automatic commit();
    qA.push_back(expVec(0));
    qB.push_back(expVec(1));
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      commit();
    end
  endtask

  task automatic expectGrant(input string name, input logic [NR-1:0] exp);
    @(negedge clk);
    checkVal(name, 64'(busA.grant), 64'(exp));
  endtask

  // Monitor: compare every observed cycle against the queued prediction.
  initial begin
    obsT e;
    obsT act;
    forever begin
      @(negedge clk);
      cycNo++;
      if (qA.size() != 0) begin
        e = qA.pop_front();
        act = {busA.grant, busA.memEnabled, busA.memAddress, busA.memDataOut,
               busA.memReadWrite, busA.revoked};
        checkVal($sformatf("obsA@%0d", cycNo), 64'(act), 64'(e));
      end
      if (qB.size() != 0) begin
        e = qB.pop_front();
        act = {busB.grant, busB.memEnabled, busB.memAddress, busB.memDataOut,
               busB.memReadWrite, busB.revoked};
        checkVal($sformatf("obsB@%0d", cycNo), 64'(act), 64'(e));
      end
      if (busB.revoked === 1'b1) revSeenB++;
    end
  end

  initial begin
    int held[NR];
    int nextExp;
    logic [NR-1:0] g;
    logic [NR-1:0] prevG;

    mMax[0] = 16;
    mMax[1] = 0;
    for (int m = 0; m < 2; m++) begin
      mOwner[m] = -1;
      mLast[m]  = NR - 1;
      mCont[m]  = 0;
      mRev[m]   = 1'b0;
    end
    resetN = 1'b0;
    req    = '1;
    addrIn = $urandom;
    dataIn = {$urandom, $urandom, $urandom, $urandom};
    rwIn   = '0;

    // Reset held with every requester asserting; first grant goes to requester 0.
    cyc(3);
    expectGrant("resetGrant", '0);
    checkVal("resetAddr", 64'(busA.memAddress), 64'(0));
    step();
    resetN = 1'b1;
    commit();
    cyc(1);
    expectGrant("firstGrant", 4'b0001);
    step();
    req = '0;
    commit();
    cyc(2);

    // Single requester 2 with a write.
    step();
    req = 4'b0100;
    addrIn[2*AW +: AW] = 8'h3C;
    dataIn[2*DW +: DW] = 32'hDEADBEEF;
    rwIn[2] = 1'b1;
    commit();
    cyc(1);
    expectGrant("singleGrant", 4'b0100);
    checkVal("singleAddr", 64'(busA.memAddress), 64'h3C);
    checkVal("singleData", 64'(busA.memDataOut), 64'hDEADBEEF);
    checkVal("singleRw", 64'(busA.memReadWrite), 64'(1));
    step();
    req = '0;
    commit();
    cyc(1);
    expectGrant("singleRelease", '0);

    // Fairness: everyone requests, releases after 2 granted cycles, re-asserts next cycle.
    for (int i = 0; i < NR; i++) held[i] = 0;
    nextExp = 3;
    prevG = '0;
    for (int t = 0; t < 48; t++) begin
      step();
      for (int i = 0; i < NR; i++) begin
        if (mOwner[0] == i) begin
          held[i]++;
          if (held[i] == 2) begin
            req[i] = 1'b0;
            held[i] = 0;
          end
        end else if (!req[i]) begin
          req[i] = 1'b1;
        end
      end
      commit();
      @(negedge clk);
      g = busA.grant;
      if (g != 0 && prevG == 0) begin
        checkVal("rrOrder", 64'(g), 64'(1) << nextExp);
        nextExp = (nextExp + 1) % NR;
      end else if (g != 0) begin
        checkVal("rrNoGap", 64'(g), 64'(prevG));
      end
      prevG = g;
    end
    step();
    req = '0;
    commit();
    cyc(3);

    // Pointer wrap: lastOwner = 1, then requesters 0 and 3 compete.
    step();
    req = 4'b0010;
    commit();
    cyc(1);
    expectGrant("ptrSetup", 4'b0010);
    step();
    req = '0;
    commit();
    cyc(1);
    step();
    req = 4'b1001;
    commit();
    cyc(1);
    expectGrant("wrapFirst", 4'b1000);
    step();
    req = 4'b0001;
    commit();
    cyc(1);
    expectGrant("wrapGap", '0);
    cyc(1);
    expectGrant("wrapSecond", 4'b0001);
    step();
    req = '0;
    commit();
    cyc(2);

    // Revocation: requester 0 owns, requester 2 waits from the first grant cycle.
    step();
    req = 4'b0001;
    commit();
    step();
    req = 4'b0101;
    commit();
    expectGrant("hold1", 4'b0001);
    for (int k = 2; k <= 16; k++) begin
      cyc(1);
      expectGrant($sformatf("hold%0d", k), 4'b0001);
    end
    cyc(1);
    expectGrant("revokeGap", '0);
    checkVal("revokePulse", 64'(busA.revoked), 64'(1));
    checkVal("noRevokeHoldB", 64'(busB.grant), 64'(4'b0001));
    cyc(1);
    expectGrant("competitor", 4'b0100);
    checkVal("revokeOnce", 64'(busA.revoked), 64'(0));
    cyc(1);
    step();
    req = 4'b0001;
    commit();
    cyc(1);
    expectGrant("regainGap", '0);
    cyc(1);
    expectGrant("regain", 4'b0001);
    cyc(60);
    step();
    req = '0;
    commit();
    cyc(2);

    // Sustained contention: instance A keeps revoking, instance B never does.
    step();
    req = 4'b0101;
    commit();
    cyc(200);
    @(negedge clk);
    checkVal("bStillOwns", 64'(busB.grant != 0), 64'(1));
    checkVal("bNeverRevoked", 64'(revSeenB), 64'(0));
    step();
    req = '0;
    commit();
    cyc(2);

    // Reset in the middle of a grant restarts the pointer at requester 0.
    step();
    req = 4'b0010;
    commit();
    cyc(1);
    expectGrant("preReset", 4'b0010);
    step();
    resetN = 1'b0;
    commit();
    cyc(1);
    expectGrant("midReset", '0);
    step();
    resetN = 1'b1;
    req = 4'b1111;
    commit();
    cyc(1);
    expectGrant("restart", 4'b0001);
    step();
    req = '0;
    commit();
    cyc(2);

    // Random traffic with occasional resets.
    for (int t = 0; t < 3000; t++) begin
      step();
      resetN = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < NR; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1;
            addrIn[i*AW +: AW] = AW'($urandom);
            dataIn[i*DW +: DW] = $urandom;
            rwIn[i] = 1'($urandom);
          end
        end else if (mOwner[0] == i || mOwner[1] == i) begin
          if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 39) == 0) begin
          req[i] = 1'b0;
        end
      end
      commit();
    end
    step();
    resetN = 1'b1;
    req = '0;
    commit();
    @(negedge clk);
    @(negedge clk);
    checkVal("queuesDrained", 64'(qA.size() + qB.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Round-robin arbiter that shares the single-port `sharedMemory` between up to `NUM_REQ` requesters, such as the memory reader and the atomic incrementers. It sits between the requesters and the memory. It grants one requester at a time and muxes that owner's address, write data and read/write strobe onto the memory port. A hold-time guard revokes a grant that blocks other waiting requesters for too long.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ADDR_WIDTH`, default 8: memory address width.
- `DATA_WIDTH`, default 32: memory data width.
- `MAX_HOLD`, default 16: maximum cycles an owner may keep the grant while another request is pending. 0 disables revocation.

Ports (name, direction, width, meaning):
- `clk`, in, 1: the single clock. All state updates on the rising edge.
- `resetN`, in, 1: synchronous, active-low reset.
- `req`, in, `NUM_REQ`: request lines; bit i belongs to requester i.
- `addrIn`, in, `NUM_REQ*ADDR_WIDTH`: packed addresses; requester i occupies slice `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `dataIn`, in, `NUM_REQ*DATA_WIDTH`: packed write data, sliced the same way.
- `readWriteIn`, in, `NUM_REQ`: per-requester strobe; 1 = write, 0 = read.
- `grant`, out, `NUM_REQ`: one-hot or all-zero grant, registered.
- `memEnabled`, out, 1: memory access enable; equals `|grant`.
- `memAddress`, out, `ADDR_WIDTH`: owner's address, or 0 when idle.
- `memDataOut`, out, `DATA_WIDTH`: owner's write data, or 0 when idle.
- `memReadWrite`, out, 1: owner's strobe, or 0 when idle.
- `revoked`, out, 1: one-cycle pulse when a grant is force-removed.

## Operation
- **Reset** (`resetN`=0 at an edge):
  - state=IDLE, `grant`=0, `revoked`=0, hold counter=0.
  - `lastOwner`=`NUM_REQ-1`, so requester 0 has first priority.
  - Reset overrides everything, including mid-grant.
- **IDLE**
  - If `req`≠0, pick the first set bit searching `lastOwner+1`, `lastOwner+2`, … modulo `NUM_REQ`.
  - Set its `grant` bit, set `lastOwner` to it, clear the hold counter, go to GRANT.
  - If `req`=0, stay in IDLE.
- **GRANT**, owner o:
  - `req[o]`=0 → `grant`=0, go to IDLE. Normal release.
  - Else, if `MAX_HOLD`≠0, some other req bit is set and the hold counter = `MAX_HOLD-1`:
    - `grant`=0, `revoked`=1 for one cycle, go to IDLE.
    - Owner o is now lowest priority in the next search.
  - Else, if another request is pending, hold counter +1.
  - Else, hold counter = 0. It resets whenever no one else is waiting.
- **Memory mux:** combinational from the registered `grant` and the input buses.
  - Selects slice o of `addrIn`/`dataIn`/`readWriteIn`.
  - Outputs are all-zero when `grant`=0.
- **Hold counter:** width `$clog2(MAX_HOLD+1)`; never wraps, saturates at `MAX_HOLD-1`.
- **Requester obligations:**
  - Keep `req` high for the whole access.
  - Hold address, data and strobe stable while granted.
  - Drop `req` to release.
  - A revoked requester may keep `req` high; it re-competes normally.
- **Arbitration gap:** there is always at least one IDLE cycle (`grant`=0) between successive owners, including the case where the same requester regains the bus.

## Timing
- Request-to-grant latency:
  - `req[i]` rising before edge N while in IDLE → `grant[i]`=1 after edge N.
  - `memEnabled` and mux outputs are valid in that same cycle.
- Release: `req[o]` low before edge N → `grant`=0 after edge N; the next owner's grant follows after edge N+1.
- Revocation: with `MAX_HOLD`=M and a competitor waiting from the first GRANT cycle, the owner keeps the grant for M cycles. `grant`=0 and `revoked`=1 hold in cycle M+1; the competitor is granted in cycle M+2.
- Simultaneous requests resolve by round-robin order only; nothing outside the `req` lines affects priority.
- `revoked` is high for exactly one cycle per revocation and never coincides with a nonzero `grant`.

## Test plan
1. **Reset:** hold `resetN`=0 for 3 cycles with `req`=4'b1111 → `grant`=0, `memEnabled`=0, `memAddress`=0, `revoked`=0 throughout. First grant after release is `grant`=4'b0001.
2. **Single requester:** `req`=4'b0100, `addrIn` slice 2=8'h3C, `readWriteIn[2]`=1, `dataIn` slice 2=32'hDEADBEEF.
   - One cycle later: `grant`=4'b0100, `memAddress`=8'h3C, `memDataOut`=32'hDEADBEEF, `memReadWrite`=1.
   - Drop `req` → `grant`=0 next cycle.
3. **Round-robin fairness:** all four request, each releasing after 2 granted cycles and re-asserting after 1 cycle → grant order 0,1,2,3,0,1,…, with exactly one idle cycle between owners. No requester is skipped.
4. **Pointer wrap:** `lastOwner`=1, then `req`=4'b1001 → `grant`=4'b1000. After its release, with `req[0]` still high → `grant`=4'b0001.
5. **Revocation:** `MAX_HOLD`=16. Requester 0 holds `req` for 100 cycles; requester 2 asserts at the first grant cycle.
   - `grant[0]` lasts 16 cycles, then `revoked` pulses once.
   - `grant`=4'b0100 two cycles after the last `grant[0]` cycle.
   - Requester 0 regains the bus after requester 2 releases.
6. **Reset mid-grant, and revocation disabled:**
   - Drop `resetN` while `grant`=4'b0010 → `grant`=0 next cycle, and the pointer restarts at requester 0.
   - With `MAX_HOLD`=0 and contention held for 200 cycles → no revocation and `revoked` stays 0.
